// File: rtl/frame_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : frame_bank_scheduler
// Purpose  : Hands per-frame dtTicks RAM banks between the laser synchronizer
//            (writer) and the laser-trigger playback engine (reader).
//            Writes land in the current fill bank. A bank is committed when
//            its last address is written. Committed banks queue in FIFO order,
//            and each mirror zero-crossing edge releases the bank in playback
//            and takes the oldest committed bank.
// Ports    : clk_i, nrst_i             clock, async active-low reset
//            wedata_i/waddr_i/wdata_i  write strobe, address, dtTicks value
//            zc_i                      mirror zero-crossing level
//            rd_step_i                 playback consumed current word
//            bank_we_o/bank_waddr_o/bank_wdata_o  registered RAM write port
//            wr_allow_o, wr_bank_o     fill bank free / fill bank index
//            rd_valid_o, rd_bank_o, rd_addr_o     playback state
//            line_done_o, underrun_o, drop_o      single-cycle event pulses
//            ready_cnt_o               committed banks awaiting playback
// Revision : 1.0  initial release
// ============================================================================
module frame_bank_scheduler #(
  parameter int FRAME_NUMBER_P  = 5,
  parameter int FRAME_COLUMNS_P = 360
) (
  input  logic                      clk_i,
  input  logic                      nrst_i,
  input  logic                      wedata_i,
  input  logic [9:0]                waddr_i,
  input  logic [15:0]               wdata_i,
  input  logic                      zc_i,
  input  logic                      rd_step_i,
  output logic [FRAME_NUMBER_P-1:0] bank_we_o,
  output logic [9:0]                bank_waddr_o,
  output logic [15:0]               bank_wdata_o,
  output logic                      wr_allow_o,
  output logic [2:0]                wr_bank_o,
  output logic                      rd_valid_o,
  output logic [2:0]                rd_bank_o,
  output logic [9:0]                rd_addr_o,
  output logic                      line_done_o,
  output logic                      underrun_o,
  output logic                      drop_o,
  output logic [3:0]                ready_cnt_o
);

  localparam logic [3:0] NUM_BANKS = 4'(FRAME_NUMBER_P);
  localparam logic [2:0] LAST_BANK = 3'(FRAME_NUMBER_P - 1);
  localparam logic [9:0] NUM_COLS  = 10'(FRAME_COLUMNS_P);
  localparam logic [9:0] LAST_COL  = 10'(FRAME_COLUMNS_P - 1);
  localparam logic [FRAME_NUMBER_P-1:0] ONE_HOT0 = {{(FRAME_NUMBER_P-1){1'b0}}, 1'b1};

  logic [2:0]                wr_ptr;
  logic [2:0]                rd_ptr;
  logic [3:0]                ready_cnt;
  logic                      playing;
  logic                      zc_q;
  logic [9:0]                rd_addr;
  logic [FRAME_NUMBER_P-1:0] bank_we;
  logic [9:0]                bank_waddr;
  logic [15:0]               bank_wdata;
  logic                      line_done;
  logic                      underrun;
  logic                      drop;

  logic [3:0] occupancy;
  logic       accept;
  logic       commit;
  logic       zc_edge;
  logic       take;
  logic [3:0] ready_nxt;

  function automatic logic [2:0] ptr_inc(input logic [2:0] p);
    return (p == LAST_BANK) ? 3'd0 : p + 3'd1;
  endfunction

  // The bank in playback still occupies a slot until the next edge releases
  // it. Occupancy grows only on commit, so a fill already under way is
  // never blocked halfway through.
  assign occupancy = ready_cnt + {3'b000, playing};
  assign wr_allow_o = (occupancy < NUM_BANKS);

  assign accept  = wedata_i & wr_allow_o & (waddr_i < NUM_COLS);
  assign commit  = accept & (waddr_i == LAST_COL);
  assign zc_edge = (zc_i != zc_q);
  // Take uses the registered count. A bank committed in this same cycle is
  // not visible to the take until the following edge.
  assign take    = zc_edge & (ready_cnt != 4'd0);

  always_comb begin
    ready_nxt = ready_cnt;
    case ({commit, take})
      2'b10:   ready_nxt = ready_cnt + 4'd1;
      2'b01:   ready_nxt = ready_cnt - 4'd1;
      default: ready_nxt = ready_cnt;
    endcase
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      wr_ptr     <= 3'd0;
      rd_ptr     <= 3'd0;
      ready_cnt  <= 4'd0;
      playing    <= 1'b0;
      zc_q       <= 1'b0;
      rd_addr    <= 10'd0;
      bank_we    <= '0;
      bank_waddr <= 10'd0;
      bank_wdata <= 16'd0;
      line_done  <= 1'b0;
      underrun   <= 1'b0;
      drop       <= 1'b0;
    end else begin
      zc_q       <= zc_i;
      bank_we    <= accept ? (ONE_HOT0 << wr_ptr) : '0;
      bank_waddr <= waddr_i;
      bank_wdata <= wdata_i;
      drop       <= wedata_i & ~accept;
      ready_cnt  <= ready_nxt;
      line_done  <= 1'b0;
      underrun   <= 1'b0;

      if (commit) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end

      if (zc_edge) begin
        // Release the bank in playback, then take the oldest ready bank.
        // The edge overrides any same-cycle step.
        if (playing) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
        playing  <= take;
        underrun <= ~take;
        rd_addr  <= 10'd0;
      end else if (rd_step_i && playing) begin
        if (rd_addr < LAST_COL) begin
          rd_addr <= rd_addr + 10'd1;
        end else begin
          line_done <= 1'b1;
        end
      end
    end
  end

  assign bank_we_o    = bank_we;
  assign bank_waddr_o = bank_waddr;
  assign bank_wdata_o = bank_wdata;
  assign wr_bank_o    = wr_ptr;
  assign rd_valid_o   = playing;
  assign rd_bank_o    = rd_ptr;
  assign rd_addr_o    = rd_addr;
  assign line_done_o  = line_done;
  assign underrun_o   = underrun;
  assign drop_o       = drop;
  assign ready_cnt_o  = ready_cnt;

endmodule
`default_nettype wire

// File: doc/frame_bank_scheduler.md
# frame_bank_scheduler

Manages the pool of per-frame dtTicks memory banks between the laser synchronizer (writer) and the laser-trigger playback engine (reader). Incoming dtTicks writes are routed to the current fill bank, and completed banks are queued in FIFO order. On each mirror zero-crossing edge, the oldest completed bank is handed to playback. The block sits between laserSynchronizer's wedata/waddr/wdata outputs and the FRAME_NUMBER_P dtTicks RAMs.

## Interface
- FRAME_NUMBER_P, 5: number of banks, 2..7.
- FRAME_COLUMNS_P, 360: words per bank, up to 1023.
- clk_i  in  1  system clock, 500 MHz.
- nrst_i  in  1  reset, asynchronous, active-low.
- wedata_i  in  1  write strobe from the synchronizer.
- waddr_i  in  10  write address within the bank.
- wdata_i  in  16  dtTicks value.
- zc_i  in  1  mirror zero-crossing level, synchronous to clk_i.
- rd_step_i  in  1  playback consumed current word.
- bank_we_o  out  FRAME_NUMBER_P  one-hot RAM write enables, registered.
- bank_waddr_o  out  10  registered copy of waddr_i.
- bank_wdata_o  out  16  registered copy of wdata_i.
- wr_allow_o  out  1  fill bank is free; writes are accepted.
- wr_bank_o  out  3  index of the current fill bank (wr_ptr).
- rd_valid_o  out  1  a bank is in playback.
- rd_bank_o  out  3  index of the playback bank (rd_ptr).
- rd_addr_o  out  10  playback word address.
- line_done_o  out  1  pulse when the last word is stepped.
- underrun_o  out  1  pulse when a zc edge finds no ready bank.
- drop_o  out  1  pulse when a write is rejected.
- ready_cnt_o  out  4  number of completed banks waiting for playback.

## Operation
State: wr_ptr, rd_ptr, ready_cnt (0..N), playing, zc_q, rd_addr.
- All of these reset to 0.
- All outputs reset to 0, except wr_allow_o = 1.

Bank occupancy:
- occupancy = ready_cnt + playing.
- wr_allow_o = (occupancy < FRAME_NUMBER_P).
- Occupancy only grows on commit, so it cannot block a fill that is already in progress.

Write path:
- An accepted write requires wedata_i & wr_allow_o & (waddr_i < FRAME_COLUMNS_P).
- On an accepted write, the next cycle shows bank_we_o = 1 << wr_ptr, with address and data registered alongside.
- Otherwise bank_we_o = 0.
- When wedata_i is high but the write is not accepted: no write, and drop_o pulses for 1 cycle.

Commit:
- Triggered by an accepted write with waddr_i == FRAME_COLUMNS_P-1.
- ready_cnt increments.
- wr_ptr advances modulo FRAME_NUMBER_P (N-1 wraps to 0).
- Write order within a bank is free; only the last address commits.

Zero-crossing edge:
- An edge is any cycle where zc_i != zc_q; zc_q <= zc_i every cycle.
- zc_i = 1 at reset release counts as an edge.
- On an edge, step 1 (release): if playing, rd_ptr advances modulo N and playing clears.
- Step 2 (take): if ready_cnt (the registered value, before any same-cycle commit) is > 0, then playing <= 1, ready_cnt decrements, and rd_addr <= 0.
- If no ready bank is available: playing <= 0 and underrun_o pulses.
- A commit and a take in the same cycle leave ready_cnt unchanged.

Playback stepping:
- rd_step_i while playing and rd_addr < FRAME_COLUMNS_P-1: rd_addr increments.
- rd_step_i at rd_addr == FRAME_COLUMNS_P-1: line_done_o pulses and rd_addr holds (saturates).
- rd_step_i while not playing is ignored.
- A zc edge in the same cycle as rd_step_i takes priority: rd_addr <= 0.

Width rule: ready_cnt and pointers never exceed N and N-1 respectively; there is no overflow path.

## Timing
- Write latency: 1 cycle from wedata_i to bank_we_o.
- wr_allow_o, wr_bank_o and ready_cnt_o reflect the commit 1 cycle after the last write is sampled.
- Zero-crossing latency: zc_i toggle sampled at edge t; rd_valid_o, rd_bank_o and rd_addr_o = 0 are visible after edge t.
- underrun_o, line_done_o and drop_o are single-cycle pulses, registered.
- Asynchronous reset mid-fill: the partial bank is discarded, all pointers return to 0, and bank_we_o deasserts immediately.

## Test plan
- Reset, no zc edges: fill banks 0-4 with 360 words each. Required: ready_cnt_o = 5 and wr_allow_o = 0. A sixth write gives drop_o = 1 and bank_we_o = 0.
- Commit bank 0, then toggle zc_i. Required: rd_valid_o = 1, rd_bank_o = 0, ready_cnt_o = 0. Next edge with nothing ready: underrun_o = 1, rd_valid_o = 0, rd_bank_o = 1.
- Write 0xABCD at waddr 17 with wr_ptr = 2. Required: bank_we_o = 5'b00100, bank_waddr_o = 17, bank_wdata_o = 0xABCD exactly 1 cycle later.
- Play a bank and issue 360 rd_step_i. Required: rd_addr_o walks 0..359, line_done_o pulses once on the 360th step, and a 361st step keeps rd_addr_o at 359.
- Last-address commit in the same cycle as a zc edge, with ready_cnt = 1 and playing. Required: ready_cnt_o stays 1, rd_bank_o advances by 1, and wr_bank_o advances.
- Wrap test: cycle through 12 fill/play rounds. Required: wr_bank_o and rd_bank_o follow 0,1,2,3,4,0,..., there are no drops or underruns, and waddr_i = 360 is rejected with drop_o = 1.
